// File: rtl/nand_ecc_pkg.sv
//==============================================================================
// Module  : nand_ecc_pkg
// Purpose : Shared constants and state encoding for the NAND sector Hamming
//           ECC generator and its read-side checker.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package nand_ecc_pkg;

  // 512-byte sector, 24-bit ECC (18 line-parity bits + 6 column-parity bits)
  localparam int SECTOR_ADDR_W = 9;
  localparam int ECC_W         = 2 * SECTOR_ADDR_W + 6;

  // Bit positions of the two parity groups inside the ECC word
  localparam int LP_BASE = 0;
  localparam int CP_BASE = 2 * SECTOR_ADDR_W;

  // Expected population count of (stored ECC ^ recomputed ECC)
  localparam int SYND_CLEAN_ONES = 0;
  localparam int SYND_CORR_ONES  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } ecc_state_t;

endpackage : nand_ecc_pkg

`default_nettype wire

// File: rtl/hamming_col_fold.sv
//==============================================================================
// Module  : hamming_col_fold
// Purpose : Folds the 8-bit running XOR of all sector bytes into the 6
//           column-parity bits. For pair j, the odd bit is the XOR of the
//           bit lanes whose index has bit j set; the even bit covers the rest.
// Ports   : col [7:0] - running XOR of every accepted byte
//           cp  [5:0] - column parity, cp[2j+1]/cp[2j] for j = 0..2
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module hamming_col_fold (
  input  logic [7:0] col,
  output logic [5:0] cp
);

  always_comb begin
    cp = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (((i >> j) & 1) != 0) begin
          cp[2*j+1] = cp[2*j+1] ^ col[i];
        end else begin
          cp[2*j] = cp[2*j] ^ col[i];
        end
      end
    end
  end

endmodule : hamming_col_fold

`default_nettype wire

// File: rtl/hamming_ecc_gen.sv
//==============================================================================
// Module  : hamming_ecc_gen
// Purpose : Streams a 2**ADDR_W byte sector and produces its Hamming ECC.
//           Line parity is accumulated per byte from the byte parity and the
//           byte address; column parity is derived from a running XOR of all
//           bytes, folded when the last byte arrives.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           start           - clear accumulators, (re)start a sector
//           din, din_valid  - byte stream, accepted only while accumulating
//           busy            - accumulating a sector
//           byte_cnt        - address of the next byte to be accepted
//           ecc, ecc_valid  - result and its one-cycle update strobe
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module hamming_ecc_gen
  import nand_ecc_pkg::*;
#(
  parameter int ADDR_W = SECTOR_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            din,
  input  logic                  din_valid,
  output logic                  busy,
  output logic [ADDR_W-1:0]     byte_cnt,
  output logic [2*ADDR_W+5:0]   ecc,
  output logic                  ecc_valid
);

  localparam int LP_W = 2 * ADDR_W;

  ecc_state_t        state;
  logic [LP_W-1:0]   lp_acc;
  logic [LP_W-1:0]   lp_next;
  logic [7:0]        col_acc;
  logic [7:0]        col_next;
  logic [5:0]        cp_next;
  logic              rp;
  logic              accept;
  logic              last;

  // start wins over a coincident byte, so the byte is dropped
  assign accept = din_valid && (state == ST_ACCUM) && !start;
  assign last   = accept && (byte_cnt == {ADDR_W{1'b1}});
  assign rp     = ^din;

  // Next line-parity value if the current byte is accepted: the byte parity
  // toggles the odd bit of pair k when address bit k is 1, else the even bit.
  always_comb begin
    lp_next = lp_acc;
    for (int k = 0; k < ADDR_W; k++) begin
      if (byte_cnt[k]) begin
        lp_next[2*k+1] = lp_acc[2*k+1] ^ rp;
      end else begin
        lp_next[2*k] = lp_acc[2*k] ^ rp;
      end
    end
  end

  assign col_next = col_acc ^ din;

  // Fold includes the current byte so the last byte lands in the same cycle
  hamming_col_fold u_col_fold (
    .col (col_next),
    .cp  (cp_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      byte_cnt  <= '0;
      lp_acc    <= '0;
      col_acc   <= '0;
      ecc       <= '0;
      ecc_valid <= 1'b0;
    end else begin
      ecc_valid <= 1'b0;
      if (start) begin
        // ecc is deliberately left alone: it keeps the previous result
        state    <= ST_ACCUM;
        busy     <= 1'b1;
        byte_cnt <= '0;
        lp_acc   <= '0;
        col_acc  <= '0;
      end else if (accept) begin
        lp_acc   <= lp_next;
        col_acc  <= col_next;
        byte_cnt <= byte_cnt + ADDR_W'(1);
        if (last) begin
          state     <= ST_DONE;
          busy      <= 1'b0;
          ecc       <= {cp_next, lp_next};
          ecc_valid <= 1'b1;
        end
      end
    end
  end

endmodule : hamming_ecc_gen

`default_nettype wire

// File: doc/hamming_ecc_gen.md
Name: hamming_ecc_gen

Overview:
Encoder side of the NAND sector ECC scheme. Computes the 24-bit Hamming ECC over a 512-byte sector as bytes stream in during page program or page read. The ECC is written to the spare area on program. On read, it is XORed with the stored ECC to form the syndrome for the existing checker (0 ones = clean, 12 ones = single-bit correctable). The block sits beside the NAND data-path byte strobe in the flash controller.

Parameters:
ADDR_W, 9, byte-address width; sector size is 2**ADDR_W bytes (512).
ECC_W, 2*ADDR_W+6 (24), ECC width; derived, not overridden.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse: clear accumulators and begin a new sector.
din  input  8  data byte.
din_valid  input  1  din is accepted this cycle when state is ACCUM.
busy  output  1  high while in ACCUM.
byte_cnt  output  ADDR_W  index of the next byte to be accepted.
ecc  output  ECC_W  computed ECC; held until next start or rst.
ecc_valid  output  1  one-cycle pulse when ecc is updated.

Behaviour:
- Reset is synchronous and active-high; there is one clock. On rst: state IDLE, busy=0, byte_cnt=0, ecc=0, ecc_valid=0, all accumulators=0.
- States:
  - IDLE -> ACCUM on start.
  - ACCUM -> DONE on acceptance of byte 2**ADDR_W-1.
  - DONE -> ACCUM on start.
  - rst returns to IDLE from any state, mid-sector included; the partial sector is discarded.
- Byte parity rp = XOR of din[7:0].
- Line parity, pair k = 0..ADDR_W-1:
  - ecc[2k+1] = XOR of rp over bytes whose address bit k = 1.
  - ecc[2k] = XOR of rp over bytes whose address bit k = 0.
- Column parity, pair j = 0..2 (bits 2*ADDR_W+2j and 2*ADDR_W+2j+1):
  - the odd bit = XOR of all data bits whose bit index has bit j = 1;
  - the even bit = XOR of those whose bit index has bit j = 0.
  - Implement with an 8-bit running XOR of all accepted bytes, folded at the end.
- Consequence: a single flipped bit at byte A, bit B makes the old/new ECC XOR contain exactly 12 ones. The odd bits read {B[2:0], A[8:0]} from LSB upward: bits 1,3,...,17 = A; bits 19,21,23 = B.
- Accepted byte = din_valid & state==ACCUM & !start. byte_cnt increments per accepted byte and wraps to 0 after the last byte.
- Gaps in din_valid are allowed; the result is independent of timing.
- Latency: ecc is registered with the final value (including the last byte) in the cycle after the last byte is accepted. ecc_valid=1 for exactly that one cycle.
- start in ACCUM: abort, clear accumulators and byte_cnt, stay in ACCUM. start has priority over a concurrent din_valid, and that byte is discarded.
- start clears neither ecc nor ecc_valid history: ecc holds its previous value until the new sector completes.
- din_valid in IDLE or DONE is ignored.
- start and rst together: rst wins.
- No inversion is applied; the spare-area write path handles any polarity convention.

Decomposition:
- Shared package nand_ecc_pkg:
  - SECTOR_ADDR_W=9, ECC_W=24;
  - LP_BASE=0, CP_BASE=18;
  - state encoding IDLE/ACCUM/DONE;
  - SYND_CLEAN_ONES=0, SYND_CORR_ONES=12.
- The column-parity fold (8-bit running XOR -> 6 bits) is a natural pure-combinational sub-module, hamming_col_fold, reused by the read-side checker tests.
- Everything else stays in one module.

Test Plan:
- 512 bytes of 0x00, back-to-back -> ecc=24'h000000; ecc_valid high exactly 1 cycle after byte 511 is accepted; busy low thereafter; byte_cnt=0.
- Byte 0 = 0x01, rest 0x00 -> ecc=24'h555555. Byte 511 = 0x80, rest 0x00 -> ecc=24'hAAAAAA. Both bytes set -> ecc=24'hFFFFFF.
- Random sector D, then D with bit 3 of byte 0x12A flipped -> XOR of the two ECCs has 12 ones; odd bits give A=0x12A, B=3.
- Random sector with random 1-3 cycle gaps in din_valid -> ecc identical to the back-to-back run.
- start after 100 bytes, then 512 bytes of 0x00 -> single ecc_valid, ecc=0. start coincident with din_valid -> that byte not counted (byte_cnt=0 next cycle).
- rst after 200 bytes -> next cycle busy=0, byte_cnt=0, ecc=0. din_valid in IDLE -> byte_cnt stays 0, no ecc_valid.
